req_sequencer: RTL and testbench
================================

# req_sequencer

Upstream feeder for the 16-to-4 encoder stage. Captures up to 16 asynchronous-in-time request pulses into a sticky pending register, selects one pending request per transfer by round-robin, and presents it as a single registered one-hot word with valid/ready handshake. Its output is guaranteed to be zero or exactly one-hot, so the downstream encoder never sees a multi-hot input.

## Interface
- `WIDTH`, 16: number of request lines. Must equal the encoder input width. Power of two.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_in`  in  WIDTH  request pulses; bit i high for one or more cycles requests service of line i.
- `onehot_out`  out  WIDTH  selected request, one-hot; all-zero when `out_valid`=0.
- `out_valid`  out  1  `onehot_out` holds a request.
- `out_ready`  in  1  downstream accepts; a transfer occurs on an edge where `out_valid` and `out_ready` are both 1.
- `pending`  out  WIDTH  sticky pending register, not yet moved to the output.
- `overrun`  out  1  one-cycle pulse: a `req_in` bit arrived while that bit was already pending.

## Operation
- Reset (`rst`=1 at an edge): `pending`=0, `onehot_out`=0, `out_valid`=0, `overrun`=0, `ptr`=0, state EMPTY. Reset dominates all other inputs on that edge.
- State machine, 2 states:
  - EMPTY (`out_valid`=0) -> FULL when `pending` is nonzero.
  - FULL (`out_valid`=1) -> FULL when a transfer occurs and `pending` is nonzero; -> EMPTY when a transfer occurs and `pending`=0; otherwise stays FULL, holding `onehot_out` stable.
- Load condition: `load` = (state EMPTY) or (transfer this edge). On load with `pending` nonzero:
  - `sel` = first set bit of `pending` searching upward from `ptr`, wrapping 15->0.
  - `onehot_out` <= 1<<`sel`.
  - Bit `sel` is cleared from `pending`.
  - `ptr` <= (`sel`+1) mod WIDTH (4-bit natural wrap).
- Pending update, each edge: `pending` <= (`pending` & ~clr) | `req_in`, where clr is the one-hot being loaded, or 0.
  - A `req_in` bit equal to the bit being loaded on the same edge stays pending. This is a new request, not an overrun.
- `overrun` <= |(`req_in` & `pending` & ~clr). It is registered and is 1 for exactly one cycle per offending edge.
- `req_in` bits held high for several cycles re-request on every edge. Callers must pulse.

## Timing
- Request sampled at edge k -> visible in `pending` after edge k -> in `onehot_out` with `out_valid`=1 after edge k+1, if the output is empty. Minimum latency is 2 cycles.
- Back-to-back throughput: one transfer per cycle while `out_ready`=1 and `pending` is nonzero. There is no bubble between transfers.
- `out_valid` never drops without a transfer. `onehot_out` does not change while `out_valid`=1 and `out_ready`=0.
- `rst` asserted mid-transfer: the output is discarded and `pending` is lost. There is no partial state.

## Configuration
- `REQ_SEQ_FIXED_PRIO_EN` defined: fixed priority. The highest set index of `pending` is selected, matching the encoder's priority order. `ptr` is not implemented.
- Undefined (default): round-robin, as described above.

## Structure
- Shared package `enc_pkg`: `ENC_IN_W`=16, `ENC_OUT_W`=4, state enum {EMPTY, FULL}.
- One sub-module, `rr_pick`: combinational pick.
  - Inputs: `pending`, `ptr`. Outputs: one-hot `grant`, `sel` index, `any`.
  - Implemented as rotate right by `ptr`, find-first-set, rotate back.
  - Macro variant: highest-set-bit pick.

## Test plan
- Reset: after `rst` for 2 cycles -> `out_valid`=0, `onehot_out`=0x0000, `pending`=0x0000, `overrun`=0.
- Single request: `req_in`=0x0010 for 1 cycle, `out_ready`=0 -> two edges later `onehot_out`=0x0010, `out_valid`=1; output held stable 5 cycles; raise `out_ready` -> next edge `out_valid`=0.
- Round-robin with wrap: `req_in`=0x8001 and 0x0100 pulsed together, `out_ready`=1 -> outputs in order 0x0001, 0x0100, 0x8000 on consecutive cycles, then `out_valid`=0. Then pulse 0x0001 and 0x8000 -> 0x0001 is selected first (`ptr`=0 after wrap).
- Backpressure and overrun: `out_ready`=0, pulse 0x0004, then pulse 0x0008, then pulse 0x0008 again -> `overrun`=1 for exactly one cycle; `pending`=0x0008.
- Same-edge re-request: while 0x0002 is being loaded, `req_in`=0x0002 -> `overrun`=0, `pending`=0x0002 after the edge, and 0x0002 is output again later.
- Reset mid-stream: `pending`=0xFFFF, `out_valid`=1, assert `rst` -> all outputs are 0 next cycle. With `REQ_SEQ_FIXED_PRIO_EN`, `req_in`=0x8001 -> 0x8000 is output first.

Source files
------------

// File: rtl/enc_pkg.sv
// enc_pkg: widths and state type shared by the request sequencer and the
// downstream 16-to-4 encoder stage.
package enc_pkg;

    localparam int ENC_IN_W  = 16;
    localparam int ENC_OUT_W = 4;

    // EMPTY: output register idle; FULL: output register holds a request.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational pick of one pending request.
// Default: round-robin starting at ptr (rotate right, find-first-set,
// rotate back). With REQ_SEQ_FIXED_PRIO_EN defined: highest set index wins
// and there is no ptr input.
module rr_pick
    import enc_pkg::*;
#(
    parameter int WIDTH = ENC_IN_W
) (
    input  logic [WIDTH-1:0]         pending,
`ifndef REQ_SEQ_FIXED_PRIO_EN
    input  logic [$clog2(WIDTH)-1:0] ptr,
`endif
    output logic [WIDTH-1:0]         grant,
    output logic [$clog2(WIDTH)-1:0] sel,
    output logic                     any
);

    localparam int IW = $clog2(WIDTH);

`ifndef REQ_SEQ_FIXED_PRIO_EN
    logic [WIDTH-1:0] rot;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    off;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then add ptr back
    // (IW-bit arithmetic gives the 15->0 wrap for free).
    always_comb begin
        rot = '0;
        idx = '0;
        off = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx    = IW'(i) + ptr;
            rot[i] = pending[idx];
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) off = IW'(i);
        end
        sel   = off + ptr;
        any   = |pending;
        grant = any ? (WIDTH'(1) << sel) : '0;
    end
`else
    // Highest set index wins, matching the encoder's own priority order.
    always_comb begin
        sel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending[i]) sel = IW'(i);
        end
        any   = |pending;
        grant = any ? (WIDTH'(1) << sel) : '0;
    end
`endif

endmodule

// File: rtl/req_sequencer.sv
// req_sequencer: captures request pulses into a sticky pending register and
// presents one of them at a time as a registered one-hot word.
// Selection is round-robin by default; define REQ_SEQ_FIXED_PRIO_EN for
// fixed highest-index-first priority.
//
// Handshake: onehot_out/out_valid are registered. A transfer happens on a
// rising edge where out_valid=1 and out_ready=1. While out_valid=1 and
// out_ready=0 the word is held unchanged; out_valid only drops on a transfer
// (or reset). onehot_out is all-zero whenever out_valid=0.
module req_sequencer
    import enc_pkg::*;
#(
    parameter int WIDTH = ENC_IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_in,
    output logic [WIDTH-1:0] onehot_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pending,
    output logic             overrun
);

    localparam int IW = $clog2(WIDTH);

    seq_state_e       state;
    seq_state_e       state_n;
    logic [WIDTH-1:0] grant;
    logic [IW-1:0]    sel;
    logic             any;
    logic             load;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] pending_n;
    logic [WIDTH-1:0] onehot_n;
    logic             overrun_n;

`ifndef REQ_SEQ_FIXED_PRIO_EN
    logic [IW-1:0]    ptr;
`endif

    rr_pick #(.WIDTH(WIDTH)) u_pick (
        .pending (pending),
`ifndef REQ_SEQ_FIXED_PRIO_EN
        .ptr     (ptr),
`endif
        .grant   (grant),
        .sel     (sel),
        .any     (any)
    );

    assign out_valid = (state == FULL);

    // Next state, output word, pending update and overrun detection.
    always_comb begin
        state_n  = state;
        onehot_n = onehot_out;
        clr      = '0;
        load     = (state == EMPTY) || (state == FULL && out_ready);
        if (load) begin
            if (any) begin
                state_n  = FULL;
                onehot_n = grant;
                clr      = grant;
            end else begin
                state_n  = EMPTY;
                onehot_n = '0;
            end
        end
        // A request for the bit being loaded this edge is a fresh request.
        overrun_n = |(req_in & pending & ~clr);
        pending_n = (pending & ~clr) | req_in;
    end

    // State, output word, pending and overrun registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            onehot_out <= '0;
            pending    <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            onehot_out <= onehot_n;
            pending    <= pending_n;
            overrun    <= overrun_n;
        end
    end

`ifndef REQ_SEQ_FIXED_PRIO_EN
    // Round-robin pointer: search restarts just above the last granted line.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load && any) begin
            ptr <= sel + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_req_sequencer.sv
// tb_req_sequencer: directed vector table for the handshake corner cases,
// then randomized traffic against a behavioural model of the sequencer.
// Honours REQ_SEQ_FIXED_PRIO_EN for the selection rule.
module tb_req_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] req_in;
    logic [W-1:0] onehot_out;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] pending;
    logic         overrun;

    int n_checks = 0;
    int n_fail   = 0;

    req_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .onehot_out (onehot_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pending    (pending),
        .overrun    (overrun)
    );

    // Clock
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, take one edge, sample 1 time unit later.
    task automatic drive_step(input logic r, input logic [W-1:0] rq, input logic rdy);
        rst       = r;
        req_in    = rq;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         rst;
        logic [W-1:0] req;
        logic         rdy;
        logic [W-1:0] oh;
        logic         v;
        logic [W-1:0] p;
        logic         ov;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [W-1:0] rq, input logic rdy,
                                input logic [W-1:0] oh, input logic v,
                                input logic [W-1:0] p, input logic ov);
        vec_t t;
        t.rst = r; t.req = rq; t.rdy = rdy; t.oh = oh; t.v = v; t.p = p; t.ov = ov;
        vecs.push_back(t);
    endfunction

    task automatic fill_table();
        // reset for two cycles
        add(1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
        add(1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
`ifndef REQ_SEQ_FIXED_PRIO_EN
        // single request, held under backpressure, then accepted
        add(0, 16'h0010, 0, 16'h0000, 0, 16'h0010, 0);
        add(0, 16'h0000, 0, 16'h0010, 1, 16'h0000, 0);
        for (int i = 0; i < 5; i++) add(0, 16'h0000, 0, 16'h0010, 1, 16'h0000, 0);
        add(0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0);
        // round-robin with wrap (fresh reset so ptr=0)
        add(1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
        add(0, 16'h8101, 1, 16'h0000, 0, 16'h8101, 0);
        add(0, 16'h0000, 1, 16'h0001, 1, 16'h8100, 0);
        add(0, 16'h0000, 1, 16'h0100, 1, 16'h8000, 0);
        add(0, 16'h0000, 1, 16'h8000, 1, 16'h0000, 0);
        add(0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0);
        add(0, 16'h8001, 1, 16'h0000, 0, 16'h8001, 0);
        add(0, 16'h0000, 1, 16'h0001, 1, 16'h8000, 0);
        add(0, 16'h0000, 1, 16'h8000, 1, 16'h0000, 0);
        add(0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0);
        // backpressure and overrun
        add(0, 16'h0004, 0, 16'h0000, 0, 16'h0004, 0);
        add(0, 16'h0008, 0, 16'h0004, 1, 16'h0008, 0);
        add(0, 16'h0008, 0, 16'h0004, 1, 16'h0008, 1);
        add(0, 16'h0000, 0, 16'h0004, 1, 16'h0008, 0);
        add(0, 16'h0000, 1, 16'h0008, 1, 16'h0000, 0);
        add(0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0);
        // same-edge re-request of the word being loaded
        add(0, 16'h0002, 0, 16'h0000, 0, 16'h0002, 0);
        add(0, 16'h0002, 0, 16'h0002, 1, 16'h0002, 0);
        add(0, 16'h0000, 1, 16'h0002, 1, 16'h0000, 0);
        add(0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0);
        // reset mid-stream with everything pending
        add(0, 16'hFFFF, 0, 16'h0000, 0, 16'hFFFF, 0);
        add(0, 16'h0000, 0, 16'h0004, 1, 16'hFFFB, 0);
        add(0, 16'hFFFF, 0, 16'h0004, 1, 16'hFFFF, 1);
        add(1, 16'hFFFF, 1, 16'h0000, 0, 16'h0000, 0);
        add(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
`else
        // fixed priority: highest index first
        add(0, 16'h8001, 0, 16'h0000, 0, 16'h8001, 0);
        add(0, 16'h0000, 0, 16'h8000, 1, 16'h0001, 0);
        add(0, 16'h0000, 1, 16'h0001, 1, 16'h0000, 0);
        add(0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0);
`endif
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_pend;
    logic [W-1:0] m_oh;
    bit           m_valid;
    int           m_ptr;
    bit           m_ovr;
    logic [W-1:0] exp_q[$];

    // Which pending line the spec's selection rule picks.
    function automatic int pick(input logic [W-1:0] p, input int start);
`ifndef REQ_SEQ_FIXED_PRIO_EN
        for (int j = 0; j < W; j++) begin
            if (p[(start + j) % W]) return (start + j) % W;
        end
`else
        for (int j = W - 1; j >= 0; j--) begin
            if (p[j]) return j;
        end
`endif
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [W-1:0] rq, input logic rdy);
        logic [W-1:0] clr;
        int           s;
        clr = '0;
        if (r) begin
            m_pend = '0; m_oh = '0; m_valid = 0; m_ptr = 0; m_ovr = 0;
            exp_q.delete();
            return;
        end
        if (!m_valid || rdy) begin
            s = pick(m_pend, m_ptr);
            if (s >= 0) begin
                m_oh    = '0;
                m_oh[s] = 1'b1;
                m_valid = 1;
                clr     = m_oh;
                m_ptr   = (s + 1) % W;
                exp_q.push_back(m_oh);
            end else begin
                m_oh    = '0;
                m_valid = 0;
            end
        end
        m_ovr  = |(rq & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | rq;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [W-1:0] rq;
        logic         rdy;
        logic [W-1:0] want;
        int           n_xfer = 0;

        rst = 1'b1; req_in = '0; out_ready = 1'b0;

        // directed vector table
        fill_table();
        for (int i = 0; i < vecs.size(); i++) begin
            drive_step(vecs[i].rst, vecs[i].req, vecs[i].rdy);
            check($sformatf("vec%0d onehot", i), 32'(onehot_out), 32'(vecs[i].oh));
            check($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].v));
            check($sformatf("vec%0d pending", i), 32'(pending), 32'(vecs[i].p));
            check($sformatf("vec%0d overrun", i), 32'(overrun), 32'(vecs[i].ov));
        end

        // randomized traffic against the model
        model_step(1'b1, '0, 1'b0);
        drive_step(1'b1, '0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            rq = '0;
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < W; b++) rq[b] = ($urandom_range(0, 9) == 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            // scoreboard: each accepted word must be the next one the model issued
            if (out_valid && rdy) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check("xfer unexpected", 32'(onehot_out), 32'h0);
                end else begin
                    want = exp_q.pop_front();
                    check("xfer word", 32'(onehot_out), 32'(want));
                end
            end
            model_step(1'b0, rq, rdy);
            drive_step(1'b0, rq, rdy);
            check("rnd onehot", 32'(onehot_out), 32'(m_oh));
            check("rnd valid", 32'(out_valid), 32'(m_valid));
            check("rnd pending", 32'(pending), 32'(m_pend));
            check("rnd overrun", 32'(overrun), 32'(m_ovr));
        end
        check("rnd saw transfers", 32'(n_xfer > 100), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
